axis_frame_rr_arbiter: RTL and testbench
========================================

// Module: axis_frame_rr_arbiter
// PURPOSE
//  Shares one NoC network-interface injection port among NUM_REQ AXI-Stream sources.
//  Arbitration is round-robin at frame granularity: a grant is held from the first beat through TLAST.
//  Sits between the tile-local AXI-Stream producers and the Single Unit Network Interface.
//  Runs entirely in the s_axis clock domain.
// PARAMETERS
//  NUM_REQ      4   number of requester ports (2..16)
//  TDATA_WIDTH  64  AXI-Stream data width in bits
//  TDEST_WIDTH  4   destination tile id width
//  TID_WIDTH    2   stream id width; must be >= $clog2(NUM_REQ)
// PORTS
//  clk_s_axis_i     in   1                    single clock
//  rst_s_axis_ni    in   1                    asynchronous reset, active-low
//  s_axis_tvalid_i  in   NUM_REQ              per-requester TVALID
//  s_axis_tready_o  out  NUM_REQ              per-requester TREADY
//  s_axis_tdata_i   in   NUM_REQ*TDATA_WIDTH  packed; requester r at [r*TDATA_WIDTH +: TDATA_WIDTH]
//  s_axis_tlast_i   in   NUM_REQ              per-requester TLAST
//  s_axis_tdest_i   in   NUM_REQ*TDEST_WIDTH  packed per-requester destination
//  m_axis_tvalid_o  out  1                    to NI
//  m_axis_tready_i  in   1                    from NI
//  m_axis_tdata_o   out  TDATA_WIDTH
//  m_axis_tlast_o   out  1
//  m_axis_tdest_o   out  TDEST_WIDTH
//  m_axis_tid_o     out  TID_WIDTH            index of the granted requester, zero-extended
//  frames_sent_o    out  32                   count of completed frames, wraps at 2^32
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, last_grant=NUM_REQ-1, grant=0, frames_sent_o=0.
//    All TREADY/TVALID outputs are 0 and data outputs are 0 while in reset.
//  - FSM states: IDLE and LOCKED.
//  - IDLE: if any s_axis_tvalid_i is set, select the first valid index searching (last_grant+1) mod NUM_REQ upward.
//    Register that index in grant; go to LOCKED on the next edge.
//    Arbitration costs exactly one bubble cycle per frame. In IDLE all TREADY=0 and m_axis_tvalid_o=0.
//  - LOCKED: combinational pass-through of the granted port, zero added latency.
//    m_axis_tvalid_o = s_axis_tvalid_i[grant]; s_axis_tready_o[grant] = m_axis_tready_i; all other TREADY=0.
//    tdata/tlast/tdest are muxed from grant; m_axis_tid_o = grant.
//  - Leaving LOCKED: a beat with m_tvalid & m_tready & m_tlast moves state to IDLE, sets last_grant=grant and increments frames_sent_o.
//  - The granted source may drop TVALID mid-frame. The grant is held; there is no timeout and no preemption.
//  - Requests from non-granted ports are ignored until the next IDLE. Their TVALID may stay high indefinitely.
//  - Single-beat frames (TLAST on the first beat) are legal: LOCKED lasts 1 cycle if TREADY=1.
//  - Output data is held stable while m_tvalid=1 and m_tready=0, because the source must hold per AXI-S and the grant is fixed.
//  - Reset mid-frame aborts the frame. After reset the arbiter restarts in IDLE at requester 0 priority.
//  - Starvation bound: a requester with TVALID held waits at most NUM_REQ-1 frames.
// STRUCTURE
//  - axis_arbiter_pkg: typedef enum logic {IDLE, LOCKED} arb_state_t; function rr_next.
//    rr_next(req, last, n) returns the rotating priority-encoder result and a found flag.
//  - Sub-module rr_priority_encoder: combinational, parameter NUM_REQ.
//    Inputs req vector and last_grant; outputs next index and valid.
//  - Top level: FSM, grant/last_grant registers, output mux, frame counter.
// TESTING
//  1. Reset: hold rst_s_axis_ni=0 with all TVALID=1 -> every TREADY=0, m_tvalid=0, frames_sent_o=0.
//  2. Single source: req1 sends a 4-beat frame, NI TREADY=1.
//     -> m_tid=1, beats appear 1 cycle after TVALID rises, frames_sent_o=1.
//  3. All 4 requesters continuously valid with 2-beat frames.
//     -> grant order 0,1,2,3,0, one idle cycle between frames; frames_sent_o=5 after 5 frames.
//  4. Backpressure: NI TREADY toggles 1,0,0,1 during req2's 3-beat frame.
//     -> tdata is stable across stalls, no beat is lost or duplicated, and TREADY to other ports stays 0.
//  5. Mid-frame bubble: req0 drops TVALID for 3 cycles between beats 2 and 3 while req3 is valid.
//     -> grant stays 0; req3 is served only after req0's TLAST.
//  6. Reset after 2 beats of a 5-beat frame -> outputs return to reset values immediately.
//     After release, req0 (valid) is granted first.

Source files
------------

// File: rtl/axis_arbiter_pkg.sv
// Shared types and the rotating priority search used by the frame arbiter.
// rr_next works on a fixed 16-wide request vector; callers zero-extend.
package axis_arbiter_pkg;

    localparam int RR_MAX_REQ = 16;
    localparam int RR_IDX_W   = 4;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_result_t;

    // First set request found scanning upward from (last + 1) mod n.
    function automatic rr_result_t rr_next(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   last,
        input int                    n
    );
        rr_result_t res;
        int         cand;
        res = '0;
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            cand = (int'(last) + k) % n;
            if (k <= n && !res.found && req[cand[RR_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Combinational round-robin pick: next requester after last_grant_i that is asking.
module rr_priority_encoder
    import axis_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   next_idx_o,
    output logic               valid_o
);

    logic [RR_MAX_REQ-1:0] req_ext;
    logic [RR_IDX_W-1:0]   last_ext;
    rr_result_t            res;

    always_comb begin
        req_ext                 = '0;
        req_ext[NUM_REQ-1:0]    = req_i;
        last_ext                = '0;
        last_ext[IDX_W-1:0]     = last_grant_i;
        res                     = rr_next(req_ext, last_ext, NUM_REQ);
        next_idx_o              = res.idx[IDX_W-1:0];
        valid_o                 = res.found;
    end

endmodule

// File: rtl/axis_frame_rr_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI-Stream NI injection port.
// One bubble cycle per frame for arbitration, then zero-latency pass-through until TLAST.
module axis_frame_rr_arbiter
    import axis_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 4,
    parameter int TID_WIDTH   = 2
) (
    input  logic                           clk_s_axis_i,
    input  logic                           rst_s_axis_ni,
    input  logic [NUM_REQ-1:0]             s_axis_tvalid_i,
    output logic [NUM_REQ-1:0]             s_axis_tready_o,
    input  logic [NUM_REQ*TDATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic [NUM_REQ-1:0]             s_axis_tlast_i,
    input  logic [NUM_REQ*TDEST_WIDTH-1:0] s_axis_tdest_i,
    output logic                           m_axis_tvalid_o,
    input  logic                           m_axis_tready_i,
    output logic [TDATA_WIDTH-1:0]         m_axis_tdata_o,
    output logic                           m_axis_tlast_o,
    output logic [TDEST_WIDTH-1:0]         m_axis_tdest_o,
    output logic [TID_WIDTH-1:0]           m_axis_tid_o,
    output logic [31:0]                    frames_sent_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a beat moves on a cycle where m_axis_tvalid_o and m_axis_tready_i
    // are both high; TREADY reaches only the granted source, and only while LOCKED.

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [31:0]      frames_q, frames_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;

    logic                   m_tvalid;
    logic [NUM_REQ-1:0]     s_tready;
    logic [TDATA_WIDTH-1:0] m_tdata;
    logic                   m_tlast;
    logic [TDEST_WIDTH-1:0] m_tdest;
    logic [TID_WIDTH-1:0]   m_tid;
    logic                   frame_done;

    rr_priority_encoder #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_enc (
        .req_i        (s_axis_tvalid_i),
        .last_grant_i (last_grant_q),
        .next_idx_o   (enc_idx),
        .valid_o      (enc_valid)
    );

    // Outputs are forced to zero outside LOCKED so reset and bubble cycles look idle.
    always_comb begin
        m_tvalid = 1'b0;
        s_tready = '0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        m_tdest  = '0;
        m_tid    = '0;
        if (state_q == LOCKED) begin
            m_tvalid          = s_axis_tvalid_i[grant_q];
            s_tready[grant_q] = m_axis_tready_i;
            m_tdata           = s_axis_tdata_i[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
            m_tlast           = s_axis_tlast_i[grant_q];
            m_tdest           = s_axis_tdest_i[int'(grant_q)*TDEST_WIDTH +: TDEST_WIDTH];
            m_tid             = TID_WIDTH'(grant_q);
        end
    end

    assign frame_done = m_tvalid & m_axis_tready_i & m_tlast;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        frames_d     = frames_q;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    grant_d = enc_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (frame_done) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                    frames_d     = frames_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to the top index so requester 0 has first priority.
    always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
        if (!rst_s_axis_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            frames_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            frames_q     <= frames_d;
        end
    end

    assign m_axis_tvalid_o = m_tvalid;
    assign s_axis_tready_o = s_tready;
    assign m_axis_tdata_o  = m_tdata;
    assign m_axis_tlast_o  = m_tlast;
    assign m_axis_tdest_o  = m_tdest;
    assign m_axis_tid_o    = m_tid;
    assign frames_sent_o   = frames_q;

endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// Bench for axis_frame_rr_arbiter: per-source frame engines, expected-beat queue, negedge monitor.
module tb_axis_frame_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int TW = 4;
    localparam int IW = 2;
    localparam int EW = IW + TW + 1 + DW;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    s_tvalid;
    logic [NR-1:0]    s_tready;
    logic [NR*DW-1:0] s_tdata;
    logic [NR-1:0]    s_tlast;
    logic [NR*TW-1:0] s_tdest;
    logic             m_tvalid;
    logic             m_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tlast;
    logic [TW-1:0]    m_tdest;
    logic [IW-1:0]    m_tid;
    logic [31:0]      frames;

    axis_frame_rr_arbiter #(
        .NUM_REQ(NR), .TDATA_WIDTH(DW), .TDEST_WIDTH(TW), .TID_WIDTH(IW)
    ) dut (
        .clk_s_axis_i    (clk),
        .rst_s_axis_ni   (rst_n),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .s_axis_tdata_i  (s_tdata),
        .s_axis_tlast_i  (s_tlast),
        .s_axis_tdest_i  (s_tdest),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .m_axis_tdata_o  (m_tdata),
        .m_axis_tlast_o  (m_tlast),
        .m_axis_tdest_o  (m_tdest),
        .m_axis_tid_o    (m_tid),
        .frames_sent_o   (frames)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int exp_frames = 0;
    int exp_fno[NR] = '{default: 0};
    int last_pop_cyc = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [DW-1:0] mk_data(input int r, input int f, input int b);
        return {16'hCAFE, r[7:0], f[7:0], b[7:0], 24'h5A5A5A};
    endfunction

    function automatic logic [TW-1:0] mk_dest(input int r);
        return TW'(r * 3 + 1);
    endfunction

    // Push the first nb beats of requester r's next frame of length len.
    task automatic push_frame(input int r, input int len, input int nb);
        for (int b = 0; b < nb; b++)
            exp_q.push_back({IW'(r), mk_dest(r), (b == len - 1), mk_data(r, exp_fno[r], b)});
        exp_fno[r]++;
        if (nb == len) exp_frames++;
    endtask

    // ---------------- source engines ----------------
    int frames_left[NR] = '{default: 0};
    int beats_per[NR]   = '{default: 1};
    int beat[NR]        = '{default: 0};
    int fno[NR]         = '{default: 0};
    int gap_at[NR]      = '{default: -1};
    int gap_len[NR]     = '{default: 0};
    int gap_cnt[NR]     = '{default: 0};
    logic [NR-1:0] acc  = '0;

    always @(negedge clk) acc <= s_tvalid & s_tready;

    task automatic drive_sources();
        for (int r = 0; r < NR; r++) begin
            s_tvalid[r]            = (frames_left[r] > 0) && (gap_cnt[r] == 0);
            s_tlast[r]             = (beat[r] == beats_per[r] - 1);
            s_tdata[r*DW +: DW]    = mk_data(r, fno[r], beat[r]);
            s_tdest[r*TW +: TW]    = mk_dest(r);
        end
    endtask

    initial begin
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tdest = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (acc[r]) begin
                    if (beat[r] == beats_per[r] - 1) begin
                        beat[r] = 0;
                        fno[r]++;
                        frames_left[r]--;
                    end else begin
                        beat[r]++;
                        if (beat[r] == gap_at[r]) begin
                            gap_cnt[r] = gap_len[r];
                            gap_at[r]  = -1;
                        end
                    end
                end else if (gap_cnt[r] > 0) begin
                    gap_cnt[r]--;
                end
            end
            drive_sources();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_beat  = '0;

    always @(negedge clk) begin
        logic [EW-1:0] got;
        got = {m_tid, m_tdest, m_tlast, m_tdata};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", {m_tvalid, got}, {1'b1, prev_beat});
            if (m_tvalid)
                check("tready_route", EW'(s_tready), EW'(NR'(m_tready) << m_tid));
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) check("unexpected_beat", got, '0);
                else check("beat", got, exp_q.pop_front());
                last_pop_cyc = cyc;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = got;
        end
    end

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, EW'(exp_q.size()), '0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check({name, "_frames"}, EW'(frames), EW'(exp_frames));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        exp_frames = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [4:0] pat;
        int start;
        rst_n    = 1'b0;
        m_tready = 1'b1;

        // 1: reset with every source asserting TVALID
        for (int r = 0; r < NR; r++) frames_left[r] = 1;
        repeat (3) @(negedge clk);
        check("rst_tvalid_in", EW'(s_tvalid), EW'(4'hF));
        check("rst_tready", EW'(s_tready), '0);
        check("rst_m_tvalid", EW'(m_tvalid), '0);
        check("rst_frames", EW'(frames), '0);
        check("rst_m_tdata", EW'(m_tdata), '0);
        for (int r = 0; r < NR; r++) frames_left[r] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2: single source, 4-beat frame from requester 1
        frames_left[1] = 1; beats_per[1] = 4;
        push_frame(1, 4, 4);
        @(negedge clk);
        check("t2_bubble", EW'(m_tvalid), '0);
        @(negedge clk);
        check("t2_first_beat", EW'({m_tvalid, m_tid}), EW'(3'b101));
        wait_drain("t2", 40);

        // 3: all sources valid, 2-beat frames, from a fresh reset
        reset_pulse();
        for (int r = 0; r < NR; r++) begin
            beats_per[r] = 2;
            frames_left[r] = (r == 0) ? 2 : 1;
        end
        push_frame(0, 2, 2); push_frame(1, 2, 2); push_frame(2, 2, 2);
        push_frame(3, 2, 2); push_frame(0, 2, 2);
        start = cyc + 1;
        wait_drain("t3", 60);
        check("t3_cycles", EW'(last_pop_cyc - start), EW'(14));

        // 4: backpressure 1,0,0,1 on requester 2's 3-beat frame; 3 and 0 wait
        @(negedge clk);
        beats_per[2] = 3; frames_left[2] = 1;
        beats_per[3] = 1; frames_left[3] = 1;
        beats_per[0] = 1; frames_left[0] = 1;
        push_frame(2, 3, 3); push_frame(3, 1, 1); push_frame(0, 1, 1);
        pat = 5'b10011;
        @(posedge clk); #1;
        for (int i = 4; i >= 0; i--) begin
            @(posedge clk); #1;
            m_tready = pat[i];
        end
        m_tready = 1'b1;
        wait_drain("t4", 60);

        // 5: requester 0 drops TVALID mid-frame while requester 3 waits
        @(negedge clk);
        beats_per[0] = 4; frames_left[0] = 1; gap_at[0] = 2; gap_len[0] = 3;
        push_frame(0, 4, 4);
        repeat (2) @(negedge clk);
        beats_per[3] = 1; frames_left[3] = 1;
        push_frame(3, 1, 1);
        repeat (3) @(negedge clk);
        check("t5_gap", EW'({m_tvalid, m_tid, s_tready[3]}), '0);
        wait_drain("t5", 60);

        // 6: reset after two beats of a 5-beat frame
        @(negedge clk);
        beats_per[0] = 5; frames_left[0] = 1;
        beats_per[2] = 1; frames_left[2] = 1;
        push_frame(0, 5, 2);
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", EW'({m_tvalid, s_tready, m_tdata, m_tid}), '0);
        check("t6_rst_frames", EW'(frames), '0);
        check("t6_rst_queue", EW'(exp_q.size()), '0);
        beat[0] = 0; fno[0]++; beats_per[0] = 2;
        exp_frames = 0;
        repeat (2) @(negedge clk);
        push_frame(0, 2, 2); push_frame(2, 1, 1);
        rst_n = 1'b1;
        wait_drain("t6", 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
